// File: rtl/parity_stream_gen.sv
// Registered odd/even parity generator for a valid/ready word stream, with packet parity,
// beat count and overlong-packet flag. Define PARITY_CHECK_EN to add the received-parity checker.
module parity_stream_gen #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16,
  localparam int CNT_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             odd_mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_par,
  output logic             m_last,
  output logic             m_pkt_par,
  output logic [CNT_W-1:0] m_len,
  output logic             m_ovf
`ifdef PARITY_CHECK_EN
  ,
  input  logic             s_par,
  output logic             err,
  output logic [7:0]       err_cnt,
  input  logic             clr_err
`endif
);

  // The internal count must hold MAX_WORDS+1 so overflow stays distinguishable.
  localparam int CNT_INT_W = $clog2(MAX_WORDS + 2);
  localparam logic [CNT_INT_W-1:0] CNT_ONE = CNT_INT_W'(1);
  localparam logic [CNT_INT_W-1:0] CNT_MAX = CNT_INT_W'(MAX_WORDS);
  localparam logic [CNT_INT_W-1:0] CNT_SAT = CNT_INT_W'(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0]     LEN_MAX = CNT_W'(MAX_WORDS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  function automatic logic f_word_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  state_t                 r_state;
  logic                   r_acc;
  logic [CNT_INT_W-1:0]   r_cnt;
  logic                   r_mode;
  logic                   r_m_valid;
  logic [WIDTH-1:0]       r_m_data;
  logic                   r_m_par;
  logic                   r_m_last;
  logic                   r_m_pkt_par;
  logic [CNT_W-1:0]       r_m_len;
  logic                   r_m_ovf;

  logic                   w_accept;
  logic                   w_in_idle;
  logic                   w_word_par;
  logic                   w_mode_eff;
  logic                   w_acc_next;
  logic [CNT_INT_W-1:0]   w_cnt_next;
  logic [CNT_W-1:0]       w_len_next;
  logic                   w_ovf_next;

  assign s_ready = !r_m_valid || m_ready;

  // Next-beat parity, mode and count; the first beat of a packet takes the live odd_mode.
  always_comb begin
    w_accept   = s_valid && s_ready;
    w_in_idle  = (r_state == ST_IDLE);
    w_word_par = f_word_par(s_data);
    w_mode_eff = r_mode;
    w_acc_next = 1'b0;
    w_cnt_next = CNT_ONE;
    if (w_in_idle) begin
      w_mode_eff = odd_mode;
      w_acc_next = w_word_par;
      w_cnt_next = CNT_ONE;
    end else begin
      w_mode_eff = r_mode;
      w_acc_next = r_acc ^ w_word_par;
      if (r_cnt >= CNT_SAT) begin
        w_cnt_next = CNT_SAT;
      end else begin
        w_cnt_next = r_cnt + CNT_ONE;
      end
    end
    if (w_cnt_next > CNT_MAX) begin
      w_len_next = LEN_MAX;
      w_ovf_next = 1'b1;
    end else begin
      w_len_next = w_cnt_next[CNT_W-1:0];
      w_ovf_next = 1'b0;
    end
  end

  // Packet FSM and the single output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= 1'b0;
      r_cnt       <= '0;
      r_mode      <= 1'b1;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_par     <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_pkt_par <= 1'b0;
      r_m_len     <= '0;
      r_m_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_m_valid <= 1'b1;
      r_m_data  <= s_data;
      r_m_par   <= w_word_par ^ w_mode_eff;
      r_m_last  <= s_last;
      case (r_state)
        ST_IDLE:   r_mode <= odd_mode;
        ST_IN_PKT: r_mode <= r_mode;
        default:   r_mode <= r_mode;
      endcase
      if (s_last) begin
        r_state     <= ST_IDLE;
        r_acc       <= 1'b0;
        r_cnt       <= '0;
        r_m_pkt_par <= w_acc_next ^ w_mode_eff;
        r_m_len     <= w_len_next;
        r_m_ovf     <= w_ovf_next;
      end else begin
        r_state     <= ST_IN_PKT;
        r_acc       <= w_acc_next;
        r_cnt       <= w_cnt_next;
        r_m_pkt_par <= 1'b0;
        r_m_len     <= '0;
        r_m_ovf     <= 1'b0;
      end
    end else if (m_ready) begin
      // Word popped with nothing behind it: packet fields must read as zero while idle.
      r_m_valid   <= 1'b0;
      r_m_pkt_par <= 1'b0;
      r_m_len     <= '0;
      r_m_ovf     <= 1'b0;
    end else begin
      r_m_valid <= r_m_valid;
    end
  end

  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_par     = r_m_par;
  assign m_last    = r_m_last;
  assign m_pkt_par = r_m_pkt_par;
  assign m_len     = r_m_len;
  assign m_ovf     = r_m_ovf;

`ifdef PARITY_CHECK_EN
  logic       r_err;
  logic [7:0] r_err_cnt;
  logic       w_mismatch;

  assign w_mismatch = w_accept && (s_par != (w_word_par ^ w_mode_eff));

  // Received-parity error pulse and saturating error count; clear loses to a coincident error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_err <= w_mismatch;
      if (clr_err) begin
        r_err_cnt <= w_mismatch ? 8'd1 : 8'd0;
      end else if (w_mismatch && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end
  end

  assign err     = r_err;
  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_parity_stream_gen.sv
// Directed self-checking bench for parity_stream_gen (WIDTH=8, MAX_WORDS=4).
module tb_parity_stream_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       odd_mode = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_par;
  logic       m_last;
  logic       m_pkt_par;
  logic [2:0] m_len;
  logic       m_ovf;
`ifdef PARITY_CHECK_EN
  logic       s_par = 1'b0;
  logic       err;
  logic [7:0] err_cnt;
  logic       clr_err = 1'b0;
`endif

  int n_total = 0;
  int n_pass  = 0;
  logic [15:0] obs;
  logic [15:0] exp_v;

  parity_stream_gen #(.WIDTH(8), .MAX_WORDS(4)) dut (
    .clk(clk), .rst(rst), .odd_mode(odd_mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_par(m_par),
    .m_last(m_last), .m_pkt_par(m_pkt_par), .m_len(m_len), .m_ovf(m_ovf)
`ifdef PARITY_CHECK_EN
    , .s_par(s_par), .err(err), .err_cnt(err_cnt), .clr_err(clr_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [7:0] d, input logic l, input logic mode);
    s_valid  = v;
    s_data   = d;
    s_last   = l;
    odd_mode = mode;
  endtask

  task automatic drain;
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    obs = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    n_total++;
    if (obs !== 16'h0000) $display("FAIL reset_outputs got %h want %h", obs, 16'h0000);
    else n_pass++;
    n_total++;
    if (s_ready !== 1'b1) $display("FAIL reset_s_ready got %b want 1", s_ready);
    else n_pass++;
  endtask

  task automatic test_single_beat;
    set_in(1'b1, 8'hA5, 1'b1, 1'b1);
    tick();
    s_valid = 1'b0;
    obs   = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    exp_v = {1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL single_beat got %h want %h", obs, exp_v);
    else n_pass++;
    tick();
    obs   = {10'd0, m_valid, m_pkt_par, m_len, m_ovf};
    n_total++;
    if (obs !== 16'h0000) $display("FAIL single_drain got %h want %h", obs, 16'h0000);
    else n_pass++;
  endtask

  task automatic test_even_packet;
    set_in(1'b1, 8'hA5, 1'b0, 1'b0);
    tick();
    obs   = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    exp_v = {1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL even_beat1 got %h want %h", obs, exp_v);
    else n_pass++;
    n_total++;
    if (s_ready !== 1'b1) $display("FAIL even_no_bubble got %b want 1", s_ready);
    else n_pass++;
    set_in(1'b1, 8'h07, 1'b0, 1'b0);
    tick();
    obs   = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    exp_v = {1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL even_beat2 got %h want %h", obs, exp_v);
    else n_pass++;
    set_in(1'b1, 8'hFF, 1'b1, 1'b0);
    tick();
    s_valid = 1'b0;
    obs   = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    exp_v = {1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL even_last got %h want %h", obs, exp_v);
    else n_pass++;
    drain();
  endtask

  task automatic test_mode_hold;
    set_in(1'b1, 8'hA5, 1'b0, 1'b1);
    tick();
    obs   = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    exp_v = {1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL hold_beat1 got %h want %h", obs, exp_v);
    else n_pass++;
    set_in(1'b1, 8'h07, 1'b0, 1'b0);
    tick();
    obs   = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    exp_v = {1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL hold_beat2 got %h want %h", obs, exp_v);
    else n_pass++;
    set_in(1'b1, 8'hFF, 1'b1, 1'b0);
    tick();
    s_valid = 1'b0;
    obs   = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    exp_v = {1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL hold_last got %h want %h", obs, exp_v);
    else n_pass++;
    drain();
  endtask

  task automatic test_backpressure;
    m_ready = 1'b0;
    set_in(1'b1, 8'h11, 1'b0, 1'b1);
    tick();
    obs   = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    exp_v = {1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL bp_first got %h want %h", obs, exp_v);
    else n_pass++;
    set_in(1'b1, 8'h22, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if ({s_ready, m_valid, m_data} !== {1'b0, 1'b1, 8'h11})
        $display("FAIL bp_stall%0d got ready=%b valid=%b data=%h want ready=0 valid=1 data=11",
                 i, s_ready, m_valid, m_data);
      else n_pass++;
      tick();
    end
    m_ready = 1'b1;
    tick();
    obs   = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    exp_v = {1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL bp_second got %h want %h", obs, exp_v);
    else n_pass++;
    set_in(1'b1, 8'h33, 1'b1, 1'b1);
    tick();
    s_valid = 1'b0;
    obs   = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    exp_v = {1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL bp_last got %h want %h", obs, exp_v);
    else n_pass++;
    drain();
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 6; i++) begin
      set_in(1'b1, 8'(i), (i == 6), 1'b0);
      tick();
    end
    s_valid = 1'b0;
    obs   = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    exp_v = {1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1};
    n_total++;
    if (obs !== exp_v) $display("FAIL ovf_last got %h want %h", obs, exp_v);
    else n_pass++;
    set_in(1'b1, 8'h01, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 8'h03, 1'b1, 1'b0);
    tick();
    s_valid = 1'b0;
    obs   = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    exp_v = {1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL ovf_next_pkt got %h want %h", obs, exp_v);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid_packet;
    set_in(1'b1, 8'h07, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 8'h03, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_valid = 1'b0;
    #1;
    obs = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    n_total++;
    if ({obs, s_ready} !== 17'h00001) $display("FAIL rst_mid_clear got %h ready=%b want 0000 ready=1", obs, s_ready);
    else n_pass++;
    set_in(1'b1, 8'h01, 1'b1, 1'b1);
    tick();
    s_valid = 1'b0;
    obs   = {m_valid, m_data, m_par, m_last, m_pkt_par, m_len, m_ovf};
    exp_v = {1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL rst_mid_fresh got %h want %h", obs, exp_v);
    else n_pass++;
    drain();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_even_packet();
    test_mode_hold();
    test_backpressure();
    test_overflow();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/parity_stream_gen.md
Name: parity_stream_gen

Overview:
Parametrised, registered parity generator for a valid/ready word stream. It generates a parity bit per word, selectable odd or even, and a running packet parity over multi-word packets delimited by a last flag. It also counts beats per packet and flags overlong packets. It sits between a data source and a link or storage stage as the sequential successor of the fixed 8-bit combinational odd-parity tree.

Parameters:
WIDTH, 8, data word width in bits (>=1)
MAX_WORDS, 16, maximum beats per packet before overflow is flagged (>=1)
CNT_W, $clog2(MAX_WORDS+1), width of the beat-count output (derived, not overridden)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
odd_mode  input  1  1 = odd parity (default use), 0 = even parity; sampled on the first beat of each packet
s_valid  input  1  upstream word valid
s_ready  output  1  block can accept a word
s_data  input  WIDTH  upstream word
s_last  input  1  final word of packet
m_valid  output  1  output word valid
m_ready  input  1  downstream accepts
m_data  output  WIDTH  registered copy of accepted word
m_par  output  1  parity bit for m_data
m_last  output  1  registered s_last
m_pkt_par  output  1  packet parity; meaningful only when m_valid&&m_last, else 0
m_len  output  CNT_W  beats in packet; meaningful only when m_valid&&m_last, else 0
m_ovf  output  1  packet exceeded MAX_WORDS; meaningful only when m_valid&&m_last, else 0

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high, on port rst.
- Reset values: m_valid=0, m_data=0, m_par=0, m_last=0, m_pkt_par=0, m_len=0, m_ovf=0. Internal state: IDLE, acc=0, cnt=0, mode latch=1.
- Reset mid-packet discards the open packet and any held output word. s_ready=1 in the cycle after reset releases.
- Single output register stage, latency 1 cycle from accept to m_valid.
- s_ready = !m_valid || m_ready, combinational. Full throughput with no bubbles.
- Accept occurs when s_valid && s_ready.
- Output holds stable while m_valid && !m_ready. s_valid without s_ready has no effect.
- On accept, mode_eff = odd_mode if in IDLE, else the latched packet mode.
  - m_par <= (^s_data) ^ mode_eff. Odd: total ones in data+par is odd. Even: total is even.
- State machine:
  - IDLE: first accepted beat latches mode, sets cnt=1 and acc=^s_data. If s_last, the single-beat packet completes and the state stays IDLE. Otherwise go to IN_PKT.
  - IN_PKT: each accept sets acc^=^s_data and cnt+=1, saturating at MAX_WORDS+1. On an accept with s_last, go to IDLE and clear acc and cnt.
- On a last-beat accept:
  - m_pkt_par <= acc_next ^ mode_eff
  - m_len <= min(cnt_next, MAX_WORDS)
  - m_ovf <= (cnt_next > MAX_WORDS)
- On non-last beats, m_pkt_par, m_len and m_ovf are 0.
- Overflow does not stall or drop data; it is flagged only on the last beat.
- A change of odd_mode mid-packet is ignored until the next packet.
- A simultaneous output pop and new accept in the same cycle is legal: the register reloads and m_valid stays 1.

Optional Feature:
Macro PARITY_CHECK_EN adds checker mode.
- Added ports: s_par input 1 (received parity for s_data), err output 1, err_cnt output 8, clr_err input 1.
- On each accept, a mismatch is computed as s_par != ((^s_data) ^ mode_eff).
- err is registered high for the one cycle after a mismatching accept.
- err_cnt increments per mismatch, saturates at 255, and resets to 0 on rst or clr_err. If clr_err and a mismatch coincide, the count becomes 1.
- Without the macro, these ports and this logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then odd_mode=1, one beat s_data=0xA5, s_last=1, m_ready=1 -> next cycle m_valid=1, m_par=1, m_pkt_par=1, m_len=1, m_ovf=0.
- odd_mode=0, packet 0xA5, 0x07, 0xFF (last on 0xFF), back-to-back -> m_par 0, 1, 0; on last beat m_pkt_par=1, m_len=3; no bubble.
- Same packet with odd_mode=1, toggling odd_mode to 0 after the first beat -> m_par 1, 0, 1; m_pkt_par=0 (mode held).
- m_ready=0 for 3 cycles with s_valid=1 -> s_ready=0, m_data frozen at the first word, nothing lost; release delivers all words in order.
- MAX_WORDS=4, send 6 beats with last on the 6th -> last beat m_len=4, m_ovf=1; the following packet of 2 beats gives m_len=2, m_ovf=0.
- Assert rst during beat 2 of a 3-beat packet, then send 1-beat packet 0x01 with odd_mode=1 -> m_par=0, m_pkt_par=0, m_len=1 (no stale acc or cnt).
